spad_pingpong: RTL
==================

SPAD_PINGPONG -- requirements
Module: spad_pingpong

Interface
REQ-001 Parameter DEPTH, default 256, words per bank.
REQ-002 Parameter ADDR_WIDTH, default 8, address bits; DEPTH <= 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 64, word width; a multiple of 8.
REQ-004 Parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable bits.
REQ-005 Parameter READ_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-006 i_clk  in  1  clock; all state updates on its rising edge.
REQ-007 i_nrst  in  1  asynchronous, active-low reset.
REQ-008 i_write_en  in  1  write strobe to the writer-owned bank.
REQ-009 i_write_addr  in  ADDR_WIDTH  write word address.
REQ-010 i_data_in  in  DATA_WIDTH  write data.
REQ-011 i_byte_en  in  BE_WIDTH  per-byte write mask; bit k covers data bits [8k+7:8k].
REQ-012 i_write_done  in  1  writer closes its current bank.
REQ-013 i_read_en  in  1  read strobe to the reader-owned bank.
REQ-014 i_read_addr  in  ADDR_WIDTH  read word address.
REQ-015 i_read_done  in  1  reader releases its current bank.
REQ-016 o_data_out  out  DATA_WIDTH  read data; zero whenever o_data_out_valid=0.
REQ-017 o_data_out_valid  out  1  read data valid.
REQ-018 o_write_ready  out  1  the writer bank is empty and writable.
REQ-019 o_read_ready  out  1  the reader bank is full and readable.
REQ-020 o_wbank, o_rbank  out  1 each  bank index currently owned by the writer / reader.
REQ-021 o_full_count  out  2  number of full banks, 0..2.

Function
REQ-022 Storage SHALL be two banks of DEPTH x DATA_WIDTH each; per-bank flag full[b]; pointers wptr and rptr.
REQ-023 o_write_ready SHALL equal !full[wptr]; o_read_ready SHALL equal full[rptr]; o_wbank=wptr; o_rbank=rptr; o_full_count=full[0]+full[1].
REQ-024 Write: when i_write_en && o_write_ready, each byte k of bank[wptr][i_write_addr] with i_byte_en[k]=1 SHALL take the matching i_data_in byte; other bytes SHALL be unchanged.
REQ-025 A write with o_write_ready=0 SHALL be dropped without side effects.
REQ-026 Close: when i_write_done && o_write_ready, full[wptr] SHALL be set and wptr SHALL toggle next cycle; a write in the same cycle SHALL land in the bank being closed.
REQ-027 i_write_done with o_write_ready=0 SHALL be ignored.
REQ-028 Read issue: when i_read_en && o_read_ready, bank[rptr][i_read_addr] SHALL appear on o_data_out with o_data_out_valid=1 exactly READ_LAT cycles later.
REQ-029 Read pipeline: one read per cycle, back-to-back reads SHALL give back-to-back valid outputs in order; valid and data SHALL move through a READ_LAT-deep register pipeline.
REQ-030 A read with o_read_ready=0 SHALL issue nothing, and READ_LAT cycles later o_data_out_valid=0 and o_data_out=0.
REQ-031 Release: when i_read_done && o_read_ready, full[rptr] SHALL clear and rptr SHALL toggle next cycle; a read in the same cycle SHALL use the bank being released, and its data SHALL still be delivered.
REQ-032 Simultaneous close and release in one cycle SHALL both take effect; they always act on different banks.
REQ-033 Addresses >= DEPTH: writes SHALL be dropped; reads SHALL return zero data with valid=1.
REQ-034 Read and write never target the same bank in a cycle, so no bypass or read-during-write hazard exists.

Reset
REQ-035 While i_nrst=0: wptr=0, rptr=0, full[1:0]=0, read pipeline valid bits=0, o_data_out=0, o_data_out_valid=0; hence o_write_ready=1, o_read_ready=0, o_full_count=0.
REQ-036 Bank contents SHALL NOT be reset; reads issued before reset SHALL never produce a valid output after reset.

Verification
REQ-037 After reset, write 0xAAAA..AA to addr 3 with byte_en=all ones, then write_done; read addr 3 -> data 0xAAAA..AA after READ_LAT cycles, valid=1, o_rbank=0.
REQ-038 Byte merge: write 0x1111..11 with all ones, then 0xFFFF..FF with byte_en=0x01 to the same address -> readback 0x1111..11FF.
REQ-039 Fill bank0, close; fill bank1, close -> o_full_count=2, o_write_ready=0; an extra write to addr 0 is dropped, and a later readback of bank0 addr 0 shows the original data.
REQ-040 READ_LAT=3: reads issued on addrs 0,1,2 in consecutive cycles with i_read_done on the third -> three consecutive valid outputs in order; rptr toggles; o_read_ready follows full[new rptr].
REQ-041 Read with o_read_ready=0 -> o_data_out_valid=0 and o_data_out=0 at +READ_LAT cycles.
REQ-042 Assert i_nrst=0 with a read in flight and both banks full -> valid never asserts; pointers=0, o_full_count=0, o_write_ready=1 after reset.

Source files
------------

// File: rtl/spad_pingpong.sv
// Ping-pong scratchpad: two DEPTH x DATA_WIDTH banks handed from writer to reader.
// The writer fills a bank and closes it. The reader drains that bank and then releases it.
// Read latency is READ_LAT cycles through a register pipeline, with one read accepted per cycle.
// Backpressure: writes and closes are ignored while o_write_ready=0.
// Reads and releases are ignored while o_read_ready=0. Such a read yields valid=0 and data=0.
// Ports: i_clk/i_nrst clock and asynchronous active-low reset.
//        i_write_* carry write strobe, address, data, byte enables and bank close.
//        i_read_* carry read strobe, address and bank release.
//        o_data_out/o_data_out_valid carry read data, which is zero whenever it is not valid.
//        o_write_ready, o_read_ready, o_wbank, o_rbank and o_full_count report bank ownership and status.
module spad_pingpong #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int READ_LAT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [BE_WIDTH-1:0]   i_byte_en,
  input  logic                  i_write_done,
  input  logic                  i_read_en,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  input  logic                  i_read_done,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_out_valid,
  output logic                  o_write_ready,
  output logic                  o_read_ready,
  output logic                  o_wbank,
  output logic                  o_rbank,
  output logic [1:0]            o_full_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic       wptr;
  logic       rptr;
  logic [1:0] full;

  logic                  write_ready;
  logic                  read_ready;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;
  logic                  do_write;
  logic                  do_close;
  logic                  rd_issue;
  logic                  do_release;
  logic [DATA_WIDTH-1:0] rd_dat;

  logic [READ_LAT-1:0]   pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat [READ_LAT];

  assign write_ready = !full[wptr];
  assign read_ready  = full[rptr];

  // Widen by one bit so that DEPTH == 2**ADDR_WIDTH does not truncate to zero.
  assign wr_in_range = {1'b0, i_write_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign rd_in_range = {1'b0, i_read_addr}  < (ADDR_WIDTH + 1)'(DEPTH);
  assign widx        = i_write_addr[IDX_W-1:0];
  assign ridx        = i_read_addr[IDX_W-1:0];

  // An out-of-range write is dropped, so it can never alias a low address through the index slice.
  assign do_write   = i_write_en   && write_ready && wr_in_range;
  assign do_close   = i_write_done && write_ready;
  assign rd_issue   = i_read_en    && read_ready;
  assign do_release = i_read_done  && read_ready;

  // Memory is read at issue time. An out-of-range read still returns valid, but with zero data.
  // Non-issued slots carry zero so that the output is zero whenever it is not valid.
  assign rd_dat = (rd_issue && rd_in_range) ? mem[rptr][ridx] : '0;

  // Bank storage is not reset. Reader and writer always own different banks, so no bypass is needed.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (i_byte_en[k]) begin
          mem[wptr][widx][8*k +: 8] <= i_data_in[8*k +: 8];
        end
      end
    end
  end

  // A close requires !full[wptr] and a release requires full[rptr], so the two always act on
  // different banks. Both can therefore take effect in the same cycle.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      full <= 2'b00;
    end else begin
      if (do_close) begin
        full[wptr] <= 1'b1;
        wptr       <= ~wptr;
      end
      if (do_release) begin
        full[rptr] <= 1'b0;
        rptr       <= ~rptr;
      end
    end
  end

  // Reset flushes reads that are in flight, so they never emerge after reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_dat[0] <= rd_dat;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign o_data_out       = pipe_dat[READ_LAT-1];
  assign o_data_out_valid = pipe_vld[READ_LAT-1];
  assign o_write_ready    = write_ready;
  assign o_read_ready     = read_ready;
  assign o_wbank          = wptr;
  assign o_rbank          = rptr;
  assign o_full_count     = {1'b0, full[0]} + {1'b0, full[1]};

endmodule
